// File: rtl/timing_gen.sv
// rtl/timing_gen.sv - four-phase W/X/Y/Z clock generator with bit-time and word counters
// Run / single-step / halt control; every output comes straight from a flop.
module timing_gen #(
    parameter  int PHASE_CYC = 2,
    parameter  int BIT_TIMES = 14,
    parameter  int FANOUT    = 8,
    localparam int BTW       = $clog2(BIT_TIMES + 1)
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              RUN,
    input  logic              STEP,
    output logic [FANOUT-1:0] W,
    output logic [FANOUT-1:0] X,
    output logic [FANOUT-1:0] Y,
    output logic [FANOUT-1:0] Z,
    output logic [1:0]        PHASE,
    output logic [BTW-1:0]    BT,
    output logic              BTE,
    output logic              TWE,
    output logic              HALTED
);

    localparam int             CW       = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CW-1:0]  CYC_LAST = CW'(PHASE_CYC - 1);
    localparam logic [BTW-1:0] BT_LAST  = BTW'(BIT_TIMES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cyc;
    logic [1:0]     r_phase;
    logic [BTW-1:0] r_bt;
    logic           r_w, r_x, r_y, r_z, r_bte, r_twe, r_halted;

    state_t         w_state_nxt;
    logic [CW-1:0]  w_cyc_nxt;
    logic [1:0]     w_phase_nxt;
    logic [BTW-1:0] w_bt_nxt;
    logic           w_active;
    logic           w_bit_end;
    logic           w_act_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_phase_nxt = r_phase;
        w_bt_nxt    = r_bt;
        w_active    = (r_state != S_IDLE);
        w_bit_end   = w_active && (r_phase == 2'd3) && (r_cyc == CYC_LAST);

        // Halt/continue is decided only at the end of a bit time, so a bit time is never cut short.
        case (r_state)
            S_IDLE: begin
                if (RUN)       w_state_nxt = S_RUN;
                else if (STEP) w_state_nxt = S_STEP;
            end
            S_RUN, S_STEP: begin
                if (w_bit_end) w_state_nxt = RUN ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_active) begin
            if (r_cyc == CYC_LAST) begin
                w_cyc_nxt   = '0;
                w_phase_nxt = r_phase + 2'd1;
                if (r_phase == 2'd3)
                    w_bt_nxt = (r_bt == BT_LAST) ? BTW'(1) : r_bt + BTW'(1);
            end else begin
                w_cyc_nxt = r_cyc + CW'(1);
            end
        end

        w_act_nxt = (w_state_nxt != S_IDLE);
    end

    // Output flops are loaded from next-state values so they line up with the counters.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_state  <= S_IDLE;
            r_cyc    <= '0;
            r_phase  <= 2'd0;
            r_bt     <= BTW'(1);
            r_w      <= 1'b0;
            r_x      <= 1'b0;
            r_y      <= 1'b0;
            r_z      <= 1'b0;
            r_bte    <= 1'b0;
            r_twe    <= 1'b0;
            r_halted <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_phase  <= w_phase_nxt;
            r_bt     <= w_bt_nxt;
            r_w      <= w_act_nxt && (w_phase_nxt == 2'd0);
            r_x      <= w_act_nxt && (w_phase_nxt == 2'd1);
            r_y      <= w_act_nxt && (w_phase_nxt == 2'd2);
            r_z      <= w_act_nxt && (w_phase_nxt == 2'd3);
            r_bte    <= w_act_nxt && (w_phase_nxt == 2'd3) && (w_cyc_nxt == CYC_LAST);
            r_twe    <= w_act_nxt && (w_phase_nxt == 2'd3) && (w_cyc_nxt == CYC_LAST)
                        && (w_bt_nxt == BT_LAST);
            r_halted <= !w_act_nxt;
        end
    end

    assign W      = {FANOUT{r_w}};
    assign X      = {FANOUT{r_x}};
    assign Y      = {FANOUT{r_y}};
    assign Z      = {FANOUT{r_z}};
    assign PHASE  = r_phase;
    assign BT     = r_bt;
    assign BTE    = r_bte;
    assign TWE    = r_twe;
    assign HALTED = r_halted;

endmodule

// File: tb/tb_timing_gen.sv
// tb/tb_timing_gen.sv - scoreboard bench for timing_gen at default parameters
module tb_timing_gen;

    logic       SIM_CLK = 1'b0;
    logic       SIM_RST;
    logic       RUN;
    logic       STEP;
    logic [7:0] W, X, Y, Z;
    logic [1:0] PHASE;
    logic [3:0] BT;
    logic       BTE, TWE, HALTED;

    timing_gen #(.PHASE_CYC(2), .BIT_TIMES(14), .FANOUT(8)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .RUN(RUN), .STEP(STEP),
        .W(W), .X(X), .Y(Y), .Z(Z), .PHASE(PHASE), .BT(BT),
        .BTE(BTE), .TWE(TWE), .HALTED(HALTED)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    typedef struct {
        logic [40:0] v;
        bit          rst;
        bit          run;
        bit          step;
    } ent_t;

    ent_t        sb[$];
    ent_t        e;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          twe_cnt;
    bit          cur_rst, cur_run, cur_step;
    logic [40:0] obs;

    assign obs = {W, X, Y, Z, PHASE, BT, BTE, TWE, HALTED};

    function automatic logic [40:0] mk(bit act, int ph, int bt, bit bte, bit twe);
        logic [7:0] w, x, y, z;
        w = (act && ph == 0) ? 8'hFF : 8'h00;
        x = (act && ph == 1) ? 8'hFF : 8'h00;
        y = (act && ph == 2) ? 8'hFF : 8'h00;
        z = (act && ph == 3) ? 8'hFF : 8'h00;
        return {w, x, y, z, 2'(ph), 4'(bt), bte, twe, !act};
    endfunction

    // Cycles idx..last of one bit time: 2 cycles per phase, BTE on the 8th cycle.
    task automatic push_bit(int bt, int first, int last);
        ent_t t;
        for (int i = first; i <= last; i++) begin
            t.v    = mk(1'b1, i / 2, bt, i == 7, (i == 7) && (bt == 14));
            t.rst  = cur_rst;
            t.run  = cur_run;
            t.step = cur_step;
            sb.push_back(t);
        end
    endtask

    task automatic push_idle(int n, int bt);
        ent_t t;
        for (int i = 0; i < n; i++) begin
            t.v    = mk(1'b0, 0, bt, 1'b0, 1'b0);
            t.rst  = cur_rst;
            t.run  = cur_run;
            t.step = cur_step;
            sb.push_back(t);
        end
    endtask

    task automatic test_reset;
        cur_rst = 1; cur_run = 0; cur_step = 0;
        push_idle(2, 1);
        cur_rst = 0; cur_run = 1;
        push_idle(1, 1);
        while (sb.size() > 0) begin
            @(posedge SIM_CLK); #1; cyc++;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %h expected %h", cyc, obs, e.v);
            end
            SIM_RST = e.rst; RUN = e.run; STEP = e.step;
        end
    endtask

    task automatic test_free_run;
        for (int b = 1; b <= 14; b++) push_bit(b, 0, 7);
        push_bit(1, 0, 7);
        twe_cnt = 0;
        while (sb.size() > 0) begin
            @(posedge SIM_CLK); #1; cyc++;
            e = sb.pop_front();
            if (TWE === 1'b1) twe_cnt++;
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL free_run cyc %0d: got %h expected %h", cyc, obs, e.v);
            end
            SIM_RST = e.rst; RUN = e.run; STEP = e.step;
        end
        n_chk++;
        if (twe_cnt !== 1) begin
            n_fail++;
            $display("FAIL twe_count: got %0d expected 1", twe_cnt);
        end
    endtask

    task automatic test_halt_resume;
        push_bit(2, 0, 1);
        cur_run = 0;
        push_bit(2, 2, 7);
        push_idle(2, 3);
        cur_run = 1;
        push_idle(1, 3);
        cur_run = 0;
        push_bit(3, 0, 3);
        cur_run = 1;
        push_bit(3, 4, 7);
        push_bit(4, 0, 5);
        cur_run = 0;
        push_bit(4, 6, 7);
        push_idle(2, 5);
        while (sb.size() > 0) begin
            @(posedge SIM_CLK); #1; cyc++;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL halt_resume cyc %0d: got %h expected %h", cyc, obs, e.v);
            end
            SIM_RST = e.rst; RUN = e.run; STEP = e.step;
        end
    endtask

    task automatic test_step;
        cur_step = 1; push_idle(1, 5);
        cur_step = 0; push_bit(5, 0, 7);
        push_idle(2, 6);
        cur_step = 1; push_idle(1, 6);
        cur_step = 0; push_bit(6, 0, 2);
        cur_step = 1; push_bit(6, 3, 3);
        cur_step = 0; push_bit(6, 4, 7);
        push_idle(1, 7);
        cur_step = 1; push_idle(1, 7);
        cur_step = 0; push_bit(7, 0, 3);
        cur_run = 1;  push_bit(7, 4, 7);
        cur_run = 0;  push_bit(8, 0, 7);
        push_idle(2, 9);
        while (sb.size() > 0) begin
            @(posedge SIM_CLK); #1; cyc++;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL step cyc %0d: got %h expected %h", cyc, obs, e.v);
            end
            SIM_RST = e.rst; RUN = e.run; STEP = e.step;
        end
    endtask

    task automatic test_run_and_step;
        cur_run = 1; cur_step = 1; push_idle(1, 9);
        cur_step = 0;
        push_bit(9, 0, 7);
        push_bit(10, 0, 0);
        cur_run = 0;
        push_bit(10, 1, 7);
        push_idle(4, 11);
        while (sb.size() > 0) begin
            @(posedge SIM_CLK); #1; cyc++;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL run_and_step cyc %0d: got %h expected %h", cyc, obs, e.v);
            end
            SIM_RST = e.rst; RUN = e.run; STEP = e.step;
        end
    endtask

    task automatic test_reset_mid;
        cur_run = 1; push_idle(1, 11);
        push_bit(11, 0, 3);
        cur_rst = 1; push_bit(11, 4, 4);
        cur_rst = 0; push_idle(1, 1);
        push_bit(1, 0, 6);
        cur_run = 0; push_bit(1, 7, 7);
        push_idle(2, 2);
        while (sb.size() > 0) begin
            @(posedge SIM_CLK); #1; cyc++;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got %h expected %h", cyc, obs, e.v);
            end
            SIM_RST = e.rst; RUN = e.run; STEP = e.step;
        end
    endtask

    initial begin
        SIM_RST = 1'b1;
        RUN     = 1'b0;
        STEP    = 1'b0;
        test_reset();
        test_free_run();
        test_halt_resume();
        test_step();
        test_run_and_step();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
